// File: rtl/control_unit.sv
// Two-phase FETCH/EXEC instruction sequencer for the data_path.
// Controls are decoded from the latched instruction register only, so instr never reaches the outputs.
module control_unit #(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [7:0]            instr,
   input  logic                  cout,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [1:0]            addr_reg,
   output logic                  sel_in,
   output logic                  sel_op,
   output logic                  carry,
   output logic                  halted
);

   typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

   localparam logic [3:0] OpNop  = 4'h0;
   localparam logic [3:0] OpInA  = 4'h1;
   localparam logic [3:0] OpInB  = 4'h2;
   localparam logic [3:0] OpAddA = 4'h3;
   localparam logic [3:0] OpSubA = 4'h4;
   localparam logic [3:0] OpAddB = 4'h5;
   localparam logic [3:0] OpOut  = 4'h6;
   localparam logic [3:0] OpJmp  = 4'h7;
   localparam logic [3:0] OpJc   = 4'h8;
   localparam logic [3:0] OpJnc  = 4'h9;
   localparam logic [3:0] OpHalt = 4'hF;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [7:0]            ir_q, ir_d;
   logic                  carry_q, carry_d;
   logic                  alu_pend_q, alu_pend_d;
   logic                  halted_q, halted_d;
   logic [ADDR_WIDTH-1:0] imm_ext;

   assign imm_ext = ADDR_WIDTH'(ir_q[3:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StFetch;
         pc_q       <= '0;
         ir_q       <= '0;
         carry_q    <= 1'b0;
         alu_pend_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         carry_q    <= carry_d;
         alu_pend_q <= alu_pend_d;
         halted_q   <= halted_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      carry_d    = carry_q;
      alu_pend_d = alu_pend_q;
      halted_d   = halted_q;
      addr_reg   = 2'd3;
      sel_in     = 1'b0;
      sel_op     = 1'b0;

      unique case (state_q)
         StFetch: begin
            if (en) begin
               ir_d    = instr;
               pc_d    = pc_q + ADDR_WIDTH'(1);
               state_d = StExec;
               // The data_path registered cout at the previous EXEC edge; pick it up now.
               if (alu_pend_q) begin
                  carry_d    = cout;
                  alu_pend_d = 1'b0;
               end
            end
         end
         StExec: begin
            if (en) state_d = StFetch;
            case (ir_q[7:4])
               OpInA: begin
                  addr_reg = 2'd0;
                  sel_in   = 1'b1;
               end
               OpInB: begin
                  addr_reg = 2'd1;
                  sel_in   = 1'b1;
               end
               OpAddA: begin
                  addr_reg = 2'd0;
                  if (en) alu_pend_d = 1'b1;
               end
               OpSubA: begin
                  addr_reg = 2'd0;
                  sel_op   = 1'b1;
                  if (en) alu_pend_d = 1'b1;
               end
               OpAddB: begin
                  addr_reg = 2'd1;
                  if (en) alu_pend_d = 1'b1;
               end
               OpOut: addr_reg = 2'd2;
               OpJmp: if (en) pc_d = imm_ext;
               OpJc:  if (en && carry_q) pc_d = imm_ext;
               OpJnc: if (en && !carry_q) pc_d = imm_ext;
               OpHalt: begin
                  if (en) begin
                     state_d  = StHalt;
                     halted_d = 1'b1;
                  end
               end
               OpNop:   ;
               default: ;
            endcase
         end
         StHalt:  ;
         default: state_d = StFetch;
      endcase
   end

   assign pc     = pc_q;
   assign carry  = carry_q;
   assign halted = halted_q;

endmodule
